mlc_seq_ctrl: RTL and testbench
===============================

MLC_SEQ_CTRL -- requirements
Module: mlc_seq_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_CH, 4, sensor channels; each is configured and drained once per capture.
- NUM_REGS, 32, register-file entries written to each channel over SPI.
- RES_ADDR, 5'h03, SPI address whose data byte is replaced by the latched resolution.
- WORDS_PER_CH, 256, data words drained per channel per capture.
- PWR_WAIT, 1000, sys_clk cycles between power-rail steps.
- OUT_W, 64, output data width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- sys_clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- mlc_cmd, in, 3, command: 1=CONFIG, 2=CAPTURE, 3=POWER_DOWN; all other values are ignored.
- mlc_res, in, 4, resolution code.
- mlc_en, in, 1, command strobe.
- mlc_idle, out, 1, high in IDLE.
- mlc_state, out, 4, current state encoding.
- mlc_5v_en, out, 1, 5V rail enable.
- mlc_3p3v_12v_en, out, 1, 3.3V/12V rail enable.
- spi_en, out, 1, one-cycle SPI start pulse.
- spi_rd_wr, out, 1, 0 = write.
- spi_addr, out, 5, SPI register address.
- spi_data, out, 8, SPI write data.
- spi_done, in, 1, one-cycle SPI completion pulse.
- spi_ch_sel, out, NUM_CH, one-hot channel select.
- reg_idx, out, 6, register-file index.
- reg_addr, in, 5, register-file address (combinational).
- reg_data, in, 8, register-file data (combinational).
- rx_if_rdy, in, 1, receive interface ready.
- cap_start, out, 1, one-cycle capture trigger.
- cap_done, in, 1, capture complete.
- cap_rd_en, out, 1, capture-buffer read strobe.
- cap_rd_data, in, OUT_W, capture-buffer data; valid the cycle after cap_rd_en.
- mlc_data, out, OUT_W, output word.
- mlc_data_valid, out, 1, output word valid.
- ddr3_ack, in, 1, output word accepted.

Function
REQ-003 States and encodings: IDLE=0, PWR_5V=1, PWR_AUX=2, CFG_ISSUE=3, CFG_WAIT=4, ARM=5, CAPTURE=6, DRAIN_RD=7, DRAIN_HOLD=8, PWR_OFF=9.
REQ-004 Command acceptance: IDLE with mlc_en=1 accepts mlc_cmd and latches mlc_res; mlc_en outside IDLE is ignored.
REQ-005 CONFIG and CAPTURE, rails off: enter PWR_5V with mlc_5v_en=1, wait PWR_WAIT cycles, go to PWR_AUX.
REQ-006 PWR_AUX: mlc_3p3v_12v_en=1, wait PWR_WAIT cycles, go to CFG_ISSUE.
REQ-007 CONFIG and CAPTURE, rails already on: go directly to CFG_ISSUE.
REQ-008 CFG_ISSUE: drive reg_idx = reg counter, spi_addr=reg_addr, spi_data=reg_data (or {4'h0,latched res} when reg_addr==RES_ADDR), spi_rd_wr=0, pulse spi_en once; go to CFG_WAIT.
REQ-009 CFG_WAIT: hold spi_addr/spi_data/spi_ch_sel stable until spi_done, then advance the counter.
REQ-010 Counter order: register index increments first; after index NUM_REGS-1, the channel increments and the register index wraps to 0.
REQ-011 After the last channel: CONFIG returns to IDLE; CAPTURE goes to ARM.
REQ-012 ARM: wait for rx_if_rdy=1, pulse cap_start one cycle, go to CAPTURE.
REQ-013 CAPTURE: wait for cap_done=1, reset the word counter, go to DRAIN_RD.
REQ-014 DRAIN_RD: pulse cap_rd_en; the next cycle, register cap_rd_data into mlc_data, assert mlc_data_valid, go to DRAIN_HOLD.
REQ-015 DRAIN_HOLD: hold mlc_data and mlc_data_valid until ddr3_ack=1, then deassert valid.
REQ-016 Drain completion: return to DRAIN_RD until NUM_CH*WORDS_PER_CH words are acknowledged, then go to IDLE.
REQ-017 Drain flow control: at most one outstanding word; valid never drops without ack.
REQ-018 POWER_DOWN: go to PWR_OFF; deassert mlc_3p3v_12v_en; wait PWR_WAIT cycles; deassert mlc_5v_en; go to IDLE.
REQ-019 POWER_DOWN with rails already off: PWR_OFF lasts one cycle.
REQ-020 Spurious inputs: spi_done outside CFG_WAIT, cap_done outside CAPTURE and ddr3_ack outside DRAIN_HOLD are ignored.
REQ-021 Simultaneous events: spi_done coinciding with the final register of the final channel advances to the next state in the same cycle as a counter advance would occur; no extra SPI transaction is issued.
REQ-022 Wait-counter width: PWR_WAIT counter is at least $clog2(PWR_WAIT+1) bits; the word counter is at least $clog2(NUM_CH*WORDS_PER_CH+1) bits.

Reset
REQ-023 Reset values with rst=1 at a sys_clk edge:
- state=IDLE; all counters 0.
- mlc_idle=1; mlc_state=0.
- rails off; spi_en=0; spi_ch_sel=0.
- cap_start=0; cap_rd_en=0.
- mlc_data=0; mlc_data_valid=0.
REQ-024 Reset mid-operation: reset in any state (including mid-SPI or mid-drain) abandons the operation and drops both rails in the same cycle.

Verification
REQ-025 Scenarios:
- CONFIG from reset, NUM_CH=2, NUM_REGS=4, PWR_WAIT=8 -> 5V at T, aux at T+8, then 8 spi_en pulses with channel 0 then 1 and addresses in register-file order, then IDLE.
- CONFIG with mlc_res=4'hA and RES_ADDR present in the register file -> that transaction carries spi_data=8'h0A.
- CAPTURE with rails on, rx_if_rdy low for 20 cycles -> cap_start fires exactly once, 1 cycle after rx_if_rdy rises.
- Drain with ddr3_ack delayed 0..5 random cycles -> all NUM_CH*WORDS_PER_CH words in order, none dropped or duplicated.
- mlc_en while busy, plus spi_done pulses in ARM -> state trace unchanged.
- rst asserted in DRAIN_HOLD -> next cycle IDLE, both rails 0, mlc_data_valid=0.

Source files
------------

// File: rtl/mlc_seq_ctrl.sv
// Sequencer for the MLC sensor front end: powers the rails, loads each channel's
// register file over SPI, triggers a capture and drains the capture buffer one word at a time.
module mlc_seq_ctrl #(
  parameter int         NUM_CH       = 4,
  parameter int         NUM_REGS     = 32,
  parameter logic [4:0] RES_ADDR     = 5'h03,
  parameter int         WORDS_PER_CH = 256,
  parameter int         PWR_WAIT     = 1000,
  parameter int         OUT_W        = 64
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [2:0]        mlc_cmd,
  input  logic [3:0]        mlc_res,
  input  logic              mlc_en,
  output logic              mlc_idle,
  output logic [3:0]        mlc_state,
  output logic              mlc_5v_en,
  output logic              mlc_3p3v_12v_en,
  output logic              spi_en,
  output logic              spi_rd_wr,
  output logic [4:0]        spi_addr,
  output logic [7:0]        spi_data,
  input  logic              spi_done,
  output logic [NUM_CH-1:0] spi_ch_sel,
  output logic [5:0]        reg_idx,
  input  logic [4:0]        reg_addr,
  input  logic [7:0]        reg_data,
  input  logic              rx_if_rdy,
  output logic              cap_start,
  input  logic              cap_done,
  output logic              cap_rd_en,
  input  logic [OUT_W-1:0]  cap_rd_data,
  output logic [OUT_W-1:0]  mlc_data,
  output logic              mlc_data_valid,
  input  logic              ddr3_ack
);

  localparam int TOTAL_WORDS = NUM_CH * WORDS_PER_CH;
  localparam int PW_W        = $clog2(PWR_WAIT + 1);
  localparam int WC_W        = $clog2(TOTAL_WORDS + 1);
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PW_W-1:0] PWR_LAST  = PW_W'(PWR_WAIT - 1);
  localparam logic [5:0]      REG_LAST  = 6'(NUM_REGS - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(TOTAL_WORDS - 1);

  localparam logic [2:0] CMD_CONFIG     = 3'd1;
  localparam logic [2:0] CMD_CAPTURE    = 3'd2;
  localparam logic [2:0] CMD_POWER_DOWN = 3'd3;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PWR_5V     = 4'd1,
    PWR_AUX    = 4'd2,
    CFG_ISSUE  = 4'd3,
    CFG_WAIT   = 4'd4,
    ARM        = 4'd5,
    CAPTURE    = 4'd6,
    DRAIN_RD   = 4'd7,
    DRAIN_HOLD = 4'd8,
    PWR_OFF    = 4'd9
  } state_t;

  state_t state, next_state;

  logic [3:0]       res_q;
  logic             is_capture;
  logic [PW_W-1:0]  pwr_cnt;
  logic [5:0]       reg_cnt;
  logic [CH_W-1:0]  ch_cnt;
  logic [WC_W-1:0]  word_cnt;
  logic             rail_5v;
  logic             rail_aux;
  logic [4:0]       addr_q;
  logic [7:0]       data_q;
  logic             rd_pend;
  logic             cap_start_q;
  logic [OUT_W-1:0] data_out_q;
  logic             valid_q;

  logic       rails_on;
  logic       pwr_done;
  logic       last_reg;
  logic       last_ch;
  logic       last_word;
  logic       is_cfg_cmd;
  logic [7:0] cfg_data;

  assign rails_on   = rail_5v & rail_aux;
  assign pwr_done   = (pwr_cnt == PWR_LAST);
  assign last_reg   = (reg_cnt == REG_LAST);
  assign last_ch    = (ch_cnt == CH_LAST);
  assign last_word  = (word_cnt == WORD_LAST);
  assign is_cfg_cmd = (mlc_cmd == CMD_CONFIG) || (mlc_cmd == CMD_CAPTURE);
  assign cfg_data   = (reg_addr == RES_ADDR) ? {4'h0, res_q} : reg_data;

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mlc_en) begin
          if (is_cfg_cmd)                     next_state = rails_on ? CFG_ISSUE : PWR_5V;
          else if (mlc_cmd == CMD_POWER_DOWN) next_state = PWR_OFF;
        end
      end
      PWR_5V:     if (pwr_done) next_state = PWR_AUX;
      PWR_AUX:    if (pwr_done) next_state = CFG_ISSUE;
      CFG_ISSUE:  next_state = CFG_WAIT;
      CFG_WAIT: begin
        if (spi_done) begin
          if (last_reg && last_ch) next_state = is_capture ? ARM : IDLE;
          else                     next_state = CFG_ISSUE;
        end
      end
      ARM:        if (rx_if_rdy) next_state = CAPTURE;
      CAPTURE:    if (cap_done)  next_state = DRAIN_RD;
      DRAIN_RD:   if (rd_pend)   next_state = DRAIN_HOLD;
      DRAIN_HOLD: if (ddr3_ack)  next_state = last_word ? IDLE : DRAIN_RD;
      PWR_OFF:    if (!rail_5v || pwr_done) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Counters, rails and the output word; a single word is in flight between read and ack.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      res_q       <= '0;
      is_capture  <= 1'b0;
      pwr_cnt     <= '0;
      reg_cnt     <= '0;
      ch_cnt      <= '0;
      word_cnt    <= '0;
      rail_5v     <= 1'b0;
      rail_aux    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_pend     <= 1'b0;
      cap_start_q <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
    end else begin
      cap_start_q <= (state == ARM) && rx_if_rdy;
      case (state)
        IDLE: begin
          if (mlc_en) begin
            res_q      <= mlc_res;
            is_capture <= (mlc_cmd == CMD_CAPTURE);
            pwr_cnt    <= '0;
            reg_cnt    <= '0;
            ch_cnt     <= '0;
            if (is_cfg_cmd && !rails_on)     rail_5v  <= 1'b1;
            if (mlc_cmd == CMD_POWER_DOWN)   rail_aux <= 1'b0;
          end
        end
        PWR_5V: begin
          if (pwr_done) begin
            pwr_cnt  <= '0;
            rail_aux <= 1'b1;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        PWR_AUX: begin
          if (pwr_done) pwr_cnt <= '0;
          else          pwr_cnt <= pwr_cnt + 1'b1;
        end
        CFG_ISSUE: begin
          addr_q <= reg_addr;
          data_q <= cfg_data;
        end
        CFG_WAIT: begin
          if (spi_done) begin
            if (last_reg) begin
              reg_cnt <= '0;
              ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
            end else begin
              reg_cnt <= reg_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (cap_done) word_cnt <= '0;
        end
        DRAIN_RD: begin
          if (!rd_pend) begin
            rd_pend <= 1'b1;
          end else begin
            rd_pend    <= 1'b0;
            data_out_q <= cap_rd_data;
            valid_q    <= 1'b1;
          end
        end
        DRAIN_HOLD: begin
          if (ddr3_ack) begin
            valid_q  <= 1'b0;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        PWR_OFF: begin
          if (!rail_5v || pwr_done) begin
            rail_5v <= 1'b0;
            pwr_cnt <= '0;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // During the issue cycle the SPI fields come straight from the register file, then from the hold registers.
  assign spi_en          = (state == CFG_ISSUE);
  assign spi_rd_wr       = 1'b0;
  assign spi_addr        = (state == CFG_ISSUE) ? reg_addr : addr_q;
  assign spi_data        = (state == CFG_ISSUE) ? cfg_data : data_q;
  assign spi_ch_sel      = ((state == CFG_ISSUE) || (state == CFG_WAIT)) ? (NUM_CH'(1) << ch_cnt) : '0;
  assign reg_idx         = reg_cnt;
  assign mlc_idle        = (state == IDLE);
  assign mlc_state       = state;
  assign mlc_5v_en       = rail_5v;
  assign mlc_3p3v_12v_en = rail_aux;
  assign cap_start       = cap_start_q;
  assign cap_rd_en       = (state == DRAIN_RD) && !rd_pend;
  assign mlc_data        = data_out_q;
  assign mlc_data_valid  = valid_q;

endmodule

// File: tb/tb_mlc_seq_ctrl.sv
// Directed bench for mlc_seq_ctrl: table-driven SPI and drain vectors plus
// hand-written sequences for power-up/down, ARM gating and reset mid-drain.
module tb_mlc_seq_ctrl;

  localparam int         NUM_CH       = 2;
  localparam int         NUM_REGS     = 4;
  localparam logic [4:0] RES_ADDR     = 5'h03;
  localparam int         WORDS_PER_CH = 4;
  localparam int         PWR_WAIT     = 8;
  localparam int         OUT_W        = 64;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        mlc_cmd = '0;
  logic [3:0]        mlc_res = '0;
  logic              mlc_en = 1'b0;
  logic              mlc_idle;
  logic [3:0]        mlc_state;
  logic              mlc_5v_en;
  logic              mlc_3p3v_12v_en;
  logic              spi_en;
  logic              spi_rd_wr;
  logic [4:0]        spi_addr;
  logic [7:0]        spi_data;
  logic              spi_done = 1'b0;
  logic [NUM_CH-1:0] spi_ch_sel;
  logic [5:0]        reg_idx;
  logic [4:0]        reg_addr;
  logic [7:0]        reg_data;
  logic              rx_if_rdy = 1'b0;
  logic              cap_start;
  logic              cap_done = 1'b0;
  logic              cap_rd_en;
  logic [OUT_W-1:0]  cap_rd_data = '0;
  logic [OUT_W-1:0]  mlc_data;
  logic              mlc_data_valid;
  logic              ddr3_ack = 1'b0;

  always #5 sys_clk = ~sys_clk;

  mlc_seq_ctrl #(
    .NUM_CH(NUM_CH), .NUM_REGS(NUM_REGS), .RES_ADDR(RES_ADDR),
    .WORDS_PER_CH(WORDS_PER_CH), .PWR_WAIT(PWR_WAIT), .OUT_W(OUT_W)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .mlc_cmd(mlc_cmd), .mlc_res(mlc_res), .mlc_en(mlc_en),
    .mlc_idle(mlc_idle), .mlc_state(mlc_state), .mlc_5v_en(mlc_5v_en),
    .mlc_3p3v_12v_en(mlc_3p3v_12v_en), .spi_en(spi_en), .spi_rd_wr(spi_rd_wr),
    .spi_addr(spi_addr), .spi_data(spi_data), .spi_done(spi_done), .spi_ch_sel(spi_ch_sel),
    .reg_idx(reg_idx), .reg_addr(reg_addr), .reg_data(reg_data), .rx_if_rdy(rx_if_rdy),
    .cap_start(cap_start), .cap_done(cap_done), .cap_rd_en(cap_rd_en),
    .cap_rd_data(cap_rd_data), .mlc_data(mlc_data), .mlc_data_valid(mlc_data_valid),
    .ddr3_ack(ddr3_ack)
  );

  // Register file contents; address 3 is the resolution slot.
  always_comb begin
    case (reg_idx[1:0])
      2'd0:    begin reg_addr = 5'h01; reg_data = 8'h5A; end
      2'd1:    begin reg_addr = 5'h03; reg_data = 8'hFF; end
      2'd2:    begin reg_addr = 5'h07; reg_data = 8'h33; end
      default: begin reg_addr = 5'h0C; reg_data = 8'hC4; end
    endcase
  end

  typedef struct {
    logic [1:0] ch_sel;
    logic [4:0] addr;
    logic [7:0] data;
    logic       is_res;
    int         done_delay;
  } spi_vec_t;

  typedef struct {
    int          ack_delay;
    logic [63:0] data;
  } drain_vec_t;

  spi_vec_t   spi_vecs[8];
  drain_vec_t drain_vecs[8];

  int n_vectors = 0;
  int n_miscompares = 0;
  int spi_en_cnt = 0;
  int cap_start_cnt = 0;
  int rd_ptr = 0;

  always @(posedge sys_clk) begin
    if (spi_en === 1'b1)    spi_en_cnt++;
    if (cap_start === 1'b1) cap_start_cnt++;
  end

  // Capture buffer: word n reads back as A5A5_0000_0000_0000 + 3n + 1, valid the cycle after the strobe.
  always @(posedge sys_clk) begin
    if (cap_rd_en === 1'b1) begin
      #1;
      cap_rd_data = 64'hA5A5_0000_0000_0000 | 64'(rd_ptr * 3 + 1);
      rd_ptr++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] cmd, input logic [3:0] res);
    mlc_cmd = cmd;
    mlc_res = res;
    mlc_en  = 1'b1;
    @(negedge sys_clk);
    mlc_en  = 1'b0;
  endtask

  task automatic runConfig(input logic [7:0] res_byte);
    int t;
    logic [7:0] exp_data;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (spi_en !== 1'b1 && t < 100) begin
        @(negedge sys_clk);
        t++;
      end
      exp_data = spi_vecs[i].is_res ? res_byte : spi_vecs[i].data;
      checkOutput($sformatf("spi_en[%0d]", i), 64'(spi_en), 64'd1);
      checkOutput($sformatf("spi_addr[%0d]", i), 64'(spi_addr), 64'(spi_vecs[i].addr));
      checkOutput($sformatf("spi_data[%0d]", i), 64'(spi_data), 64'(exp_data));
      checkOutput($sformatf("spi_ch_sel[%0d]", i), 64'(spi_ch_sel), 64'(spi_vecs[i].ch_sel));
      checkOutput($sformatf("spi_rd_wr[%0d]", i), 64'(spi_rd_wr), 64'd0);
      @(negedge sys_clk);
      repeat (spi_vecs[i].done_delay) @(negedge sys_clk);
      checkOutput($sformatf("spi_hold[%0d]", i), 64'({spi_en, spi_ch_sel, spi_addr, spi_data}),
                  64'({1'b0, spi_vecs[i].ch_sel, spi_vecs[i].addr, exp_data}));
      spi_done = 1'b1;
      @(negedge sys_clk);
      spi_done = 1'b0;
    end
  endtask

  task automatic runDrain();
    int t;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (mlc_data_valid !== 1'b1 && t < 50) begin
        @(negedge sys_clk);
        t++;
      end
      checkOutput($sformatf("drain_data[%0d]", i), mlc_data, drain_vecs[i].data);
      checkOutput($sformatf("drain_state[%0d]", i), 64'(mlc_state), 64'd8);
      repeat (drain_vecs[i].ack_delay) @(negedge sys_clk);
      checkOutput($sformatf("drain_hold[%0d]", i), {mlc_data[62:0], mlc_data_valid},
                  {drain_vecs[i].data[62:0], 1'b1});
      ddr3_ack = 1'b1;
      @(negedge sys_clk);
      ddr3_ack = 1'b0;
      checkOutput($sformatf("drain_release[%0d]", i), 64'(mlc_data_valid), 64'd0);
    end
  endtask

  initial begin
    int base_spi;
    int base_cap;
    int arm_bad;
    int t;

    spi_vecs[0] = '{2'b01, 5'h01, 8'h5A, 1'b0, 0};
    spi_vecs[1] = '{2'b01, 5'h03, 8'hFF, 1'b1, 2};
    spi_vecs[2] = '{2'b01, 5'h07, 8'h33, 1'b0, 1};
    spi_vecs[3] = '{2'b01, 5'h0C, 8'hC4, 1'b0, 3};
    spi_vecs[4] = '{2'b10, 5'h01, 8'h5A, 1'b0, 0};
    spi_vecs[5] = '{2'b10, 5'h03, 8'hFF, 1'b1, 1};
    spi_vecs[6] = '{2'b10, 5'h07, 8'h33, 1'b0, 4};
    spi_vecs[7] = '{2'b10, 5'h0C, 8'hC4, 1'b0, 0};

    drain_vecs[0] = '{0, 64'hA5A5_0000_0000_0001};
    drain_vecs[1] = '{3, 64'hA5A5_0000_0000_0004};
    drain_vecs[2] = '{1, 64'hA5A5_0000_0000_0007};
    drain_vecs[3] = '{5, 64'hA5A5_0000_0000_000A};
    drain_vecs[4] = '{2, 64'hA5A5_0000_0000_000D};
    drain_vecs[5] = '{0, 64'hA5A5_0000_0000_0010};
    drain_vecs[6] = '{4, 64'hA5A5_0000_0000_0013};
    drain_vecs[7] = '{1, 64'hA5A5_0000_0000_0016};

    // Reset values
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_state", 64'(mlc_state), 64'd0);
    checkOutput("rst_idle", 64'(mlc_idle), 64'd1);
    checkOutput("rst_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'd0);
    checkOutput("rst_spi", 64'({spi_en, spi_ch_sel}), 64'd0);
    checkOutput("rst_cap", 64'({cap_start, cap_rd_en}), 64'd0);
    checkOutput("rst_data", mlc_data, 64'd0);
    checkOutput("rst_valid", 64'(mlc_data_valid), 64'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Unknown command stays in IDLE
    applyStimulus(3'd6, 4'h0);
    checkOutput("bad_cmd_state", 64'(mlc_state), 64'd0);

    // CONFIG from reset: 5V immediately, aux PWR_WAIT cycles later
    applyStimulus(3'd1, 4'hA);
    checkOutput("pwr5v_state", 64'(mlc_state), 64'd1);
    checkOutput("pwr5v_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'b10);
    repeat (7) @(negedge sys_clk);
    checkOutput("aux_not_yet", 64'(mlc_3p3v_12v_en), 64'd0);
    @(negedge sys_clk);
    checkOutput("aux_on_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'b11);
    checkOutput("aux_state", 64'(mlc_state), 64'd2);
    base_spi = spi_en_cnt;
    runConfig(8'h0A);
    checkOutput("config_done_state", 64'(mlc_state), 64'd0);
    checkOutput("config_spi_count", 64'(spi_en_cnt - base_spi), 64'd8);
    checkOutput("config_rails_on", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'b11);

    // CAPTURE with rails on skips power-up
    applyStimulus(3'd2, 4'h5);
    checkOutput("cap_direct_cfg", 64'(mlc_state), 64'd3);
    base_spi = spi_en_cnt;
    runConfig(8'h05);
    checkOutput("arm_state", 64'(mlc_state), 64'd5);
    checkOutput("cap_spi_count", 64'(spi_en_cnt - base_spi), 64'd8);

    // ARM ignores spi_done and mlc_en while rx_if_rdy is low
    base_cap = cap_start_cnt;
    base_spi = spi_en_cnt;
    arm_bad = 0;
    mlc_cmd = 3'd3;
    for (int k = 0; k < 20; k++) begin
      spi_done = (k % 5 == 0);
      mlc_en   = (k == 7);
      @(negedge sys_clk);
      if (mlc_state !== 4'd5) arm_bad++;
    end
    spi_done = 1'b0;
    mlc_en   = 1'b0;
    checkOutput("arm_trace_stable", 64'(arm_bad), 64'd0);
    checkOutput("arm_no_cap_start", 64'(cap_start_cnt - base_cap), 64'd0);
    checkOutput("arm_no_spi", 64'(spi_en_cnt - base_spi), 64'd0);
    checkOutput("arm_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'b11);
    rx_if_rdy = 1'b1;
    @(negedge sys_clk);
    checkOutput("cap_start_pulse", 64'(cap_start), 64'd1);
    checkOutput("capture_state", 64'(mlc_state), 64'd6);
    @(negedge sys_clk);
    checkOutput("cap_start_drop", 64'(cap_start), 64'd0);

    // Spurious ack in CAPTURE, then cap_done starts the drain
    ddr3_ack = 1'b1;
    repeat (3) @(negedge sys_clk);
    ddr3_ack = 1'b0;
    checkOutput("capture_hold", 64'(mlc_state), 64'd6);
    cap_done = 1'b1;
    @(negedge sys_clk);
    cap_done = 1'b0;
    checkOutput("drain_rd_state", 64'(mlc_state), 64'd7);
    checkOutput("drain_rd_en", 64'(cap_rd_en), 64'd1);
    runDrain();
    checkOutput("drain_done_state", 64'(mlc_state), 64'd0);
    checkOutput("drain_reads", 64'(rd_ptr), 64'd8);
    checkOutput("cap_start_once", 64'(cap_start_cnt - base_cap), 64'd1);

    // Reset while holding a word
    applyStimulus(3'd2, 4'h1);
    runConfig(8'h01);
    t = 0;
    while (mlc_state !== 4'd6 && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    checkOutput("rst_case_capture", 64'(mlc_state), 64'd6);
    cap_done = 1'b1;
    @(negedge sys_clk);
    cap_done = 1'b0;
    t = 0;
    while (mlc_data_valid !== 1'b1 && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    checkOutput("rst_case_word", mlc_data, 64'hA5A5_0000_0000_0019);
    checkOutput("rst_case_hold", 64'(mlc_state), 64'd8);
    rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("midrst_state", 64'(mlc_state), 64'd0);
    checkOutput("midrst_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'd0);
    checkOutput("midrst_valid", 64'(mlc_data_valid), 64'd0);
    rst = 1'b0;
    rx_if_rdy = 1'b0;
    @(negedge sys_clk);

    // POWER_DOWN with rails already off lasts one cycle
    applyStimulus(3'd3, 4'h0);
    checkOutput("pd_off_state", 64'(mlc_state), 64'd9);
    @(negedge sys_clk);
    checkOutput("pd_off_idle", 64'(mlc_state), 64'd0);

    // POWER_DOWN with rails on: aux drops first, 5V after PWR_WAIT
    applyStimulus(3'd1, 4'h0);
    runConfig(8'h00);
    checkOutput("pd_cfg_idle", 64'(mlc_state), 64'd0);
    applyStimulus(3'd3, 4'h0);
    checkOutput("pd_on_state", 64'(mlc_state), 64'd9);
    checkOutput("pd_on_rails", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'b10);
    repeat (7) @(negedge sys_clk);
    checkOutput("pd_5v_still_on", 64'(mlc_5v_en), 64'd1);
    @(negedge sys_clk);
    checkOutput("pd_rails_off", 64'({mlc_5v_en, mlc_3p3v_12v_en}), 64'd0);
    checkOutput("pd_idle", 64'(mlc_state), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
